// File: rtl/divisor_punto_flotante.sv
// 9-bit floating-point divider: {sign, exp[3:0] bias 7, mant[3:0]} with hidden 1.
// Restoring division of the 5-bit significands, one quotient bit per cycle,
// then normalisation and saturation on exponent over/underflow.
module divisor_punto_flotante (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [8:0] i_dividendo,
  input  logic [8:0] i_divisor,
  input  logic       i_valid,
  output logic       o_ready,
  output logic [8:0] o_cociente,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_overflow,
  output logic       o_underflow
);

  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  rem_q, rem_d;
  logic [4:0]  div_q, div_d;
  logic [5:0]  quo_q, quo_d;
  logic [3:0]  e1_q, e1_d, e2_q, e2_d;
  logic        sign_q, sign_d;
  logic [8:0]  coc_q, coc_d;
  logic        ovf_q, ovf_d, unf_q, unf_d;
  logic        ready_q, ready_d, valid_q, valid_d;

  // datapath helpers for the current DIVIDE step
  logic        q_bit;
  logic [5:0]  rem_sub, rem_kept;
  logic [5:0]  quo_nxt;
  logic signed [5:0] exp_s;
  logic [3:0]  mant_n;

  // Restoring step, exponent arithmetic and next-state logic
  always_comb begin
    q_bit    = (rem_q >= {1'b0, div_q});
    rem_sub  = rem_q - {1'b0, div_q};
    rem_kept = q_bit ? rem_sub : rem_q;
    quo_nxt  = {quo_q[4:0], q_bit};
    // Range is -9..22, so 6-bit signed holds every case.
    exp_s    = $signed({2'b00, e1_q}) - $signed({2'b00, e2_q}) + 6'sd7
               - (quo_nxt[5] ? 6'sd0 : 6'sd1);
    mant_n   = quo_nxt[5] ? quo_nxt[4:1] : quo_nxt[3:0];

    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    div_d   = div_q;
    quo_d   = quo_q;
    e1_d    = e1_q;
    e2_d    = e2_q;
    sign_d  = sign_q;
    coc_d   = coc_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    ready_d = ready_q;
    valid_d = valid_q;

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          state_d = DIVIDE;
          cnt_d   = 4'd5;
          rem_d   = {2'b01, i_dividendo[3:0]};
          div_d   = {1'b1, i_divisor[3:0]};
          quo_d   = '0;
          e1_d    = i_dividendo[7:4];
          e2_d    = i_divisor[7:4];
          sign_d  = i_dividendo[8] ^ i_divisor[8];
          ready_d = 1'b0;
        end
      end
      DIVIDE: begin
        quo_d = quo_nxt;
        // remainder after a step is below D (<=31), so the shift never loses a bit
        rem_d = {rem_kept[4:0], 1'b0};
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          valid_d = 1'b1;
          if (exp_s > 6'sd15) begin
            coc_d = {sign_q, 8'hFF};
            ovf_d = 1'b1;
            unf_d = 1'b0;
          end else if (exp_s < 6'sd0) begin
            coc_d = {sign_q, 8'h00};
            ovf_d = 1'b0;
            unf_d = 1'b1;
          end else begin
            coc_d = {sign_q, exp_s[3:0], mant_n};
            ovf_d = 1'b0;
            unf_d = 1'b0;
          end
        end
      end
      DONE: begin
        if (i_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  // State, datapath and registered outputs; reset aborts any operation
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      quo_q   <= '0;
      e1_q    <= '0;
      e2_q    <= '0;
      sign_q  <= 1'b0;
      coc_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      quo_q   <= quo_d;
      e1_q    <= e1_d;
      e2_q    <= e2_d;
      sign_q  <= sign_d;
      coc_q   <= coc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign o_ready     = ready_q;
  assign o_valid     = valid_q;
  assign o_cociente  = coc_q;
  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;

endmodule

// File: tb/tb_divisor_punto_flotante.sv
// Directed bench for divisor_punto_flotante: hand-computed quotients,
// latency, DONE hold behaviour and reset abort.
module tb_divisor_punto_flotante;

  logic       i_clk;
  logic       i_rst_n;
  logic [8:0] i_dividendo;
  logic [8:0] i_divisor;
  logic       i_valid;
  logic       o_ready;
  logic [8:0] o_cociente;
  logic       o_valid;
  logic       i_ready;
  logic       o_overflow;
  logic       o_underflow;

  int checks = 0;
  int errors = 0;

  divisor_punto_flotante dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_dividendo (i_dividendo),
    .i_divisor   (i_divisor),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .o_cociente  (o_cociente),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Accept one operation, check 6-cycle latency and result, then hand it off.
  task automatic run_div(input string name, input logic [8:0] a, input logic [8:0] b,
                         input logic [8:0] exp_q, input logic exp_ovf, input logic exp_unf);
    int waited;
    waited = 0;
    while (o_ready !== 1'b1 && waited < 20) begin
      @(posedge i_clk); #1; waited++;
    end
    checks++;
    if (o_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready_wait: o_ready=%b required 1", name, o_ready);
    end
    @(negedge i_clk);
    i_dividendo = a; i_divisor = b; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    checks++;
    if (o_ready !== 1'b0) begin
      errors++; $display("FAIL %s ready_after_accept: o_ready=%b required 0", name, o_ready);
    end
    for (int k = 1; k <= 5; k++) begin
      @(posedge i_clk); #1;
      checks++;
      if (o_valid !== 1'b0) begin
        errors++; $display("FAIL %s early_valid cycle %0d: o_valid=%b required 0", name, k, o_valid);
      end
    end
    @(posedge i_clk); #1;
    checks++;
    if (o_valid !== 1'b1) begin
      errors++; $display("FAIL %s latency: o_valid=%b required 1", name, o_valid);
    end
    checks++;
    if (o_cociente !== exp_q || o_overflow !== exp_ovf || o_underflow !== exp_unf) begin
      errors++;
      $display("FAIL %s result: got q=%b ovf=%b unf=%b required q=%b ovf=%b unf=%b",
               name, o_cociente, o_overflow, o_underflow, exp_q, exp_ovf, exp_unf);
    end
    @(negedge i_clk);
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++; $display("FAIL %s handoff: o_ready=%b o_valid=%b required 1/0", name, o_ready, o_valid);
    end
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_dividendo = '0; i_divisor = '0;
    repeat (2) @(posedge i_clk);
    #1;
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_cociente !== 9'd0 ||
        o_overflow !== 1'b0 || o_underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b q=%b ovf=%b unf=%b required 1 0 0 0 0",
               o_ready, o_valid, o_cociente, o_overflow, o_underflow);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic test_basic;
    run_div("one_div_one",   9'b0_0111_0000, 9'b0_0111_0000, 9'b0_0111_0000, 1'b0, 1'b0);
    run_div("three_div_m1p5", 9'b0_1000_1000, 9'b1_0111_1000, 9'b1_1000_0000, 1'b0, 1'b0);
    run_div("one_div_1p5",   9'b0_0111_0000, 9'b0_0111_1000, 9'b0_0110_0101, 1'b0, 1'b0);
    run_div("1p5_div_one",   9'b0_0111_1000, 9'b0_0111_0000, 9'b0_0111_1000, 1'b0, 1'b0);
    run_div("one_div_max",   9'b0_0111_0000, 9'b0_0111_1111, 9'b0_0110_0000, 1'b0, 1'b0);
  endtask

  task automatic test_limits;
    run_div("overflow",      9'b0_1111_0000, 9'b0_0000_0000, 9'b0_1111_1111, 1'b1, 1'b0);
    run_div("underflow",     9'b0_0000_0000, 9'b0_1111_0000, 9'b0_0000_0000, 1'b0, 1'b1);
    run_div("exp_15_edge",   9'b0_1111_0000, 9'b0_0111_0000, 9'b0_1111_0000, 1'b0, 1'b0);
    run_div("exp_0_edge",    9'b0_0000_0000, 9'b0_0111_0000, 9'b0_0000_0000, 1'b0, 1'b0);
  endtask

  // Result must hold while i_ready is low, and new i_valid must be ignored.
  task automatic test_hold;
    @(negedge i_clk);
    i_dividendo = 9'b0_1000_1000; i_divisor = 9'b1_0111_1000; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (6) @(posedge i_clk);
    #1;
    checks++;
    if (o_valid !== 1'b1 || o_cociente !== 9'b1_1000_0000) begin
      errors++; $display("FAIL hold_start: vld=%b q=%b required 1 110000000", o_valid, o_cociente);
    end
    @(negedge i_clk);
    i_dividendo = 9'b0_0111_0000; i_divisor = 9'b0_0111_1000; i_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge i_clk); #1;
      checks++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_cociente !== 9'b1_1000_0000) begin
        errors++;
        $display("FAIL hold cycle %0d: vld=%b rdy=%b q=%b required 1 0 110000000",
                 k, o_valid, o_ready, o_cociente);
      end
    end
    @(negedge i_clk);
    i_valid = 1'b0; i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++; $display("FAIL hold_release: rdy=%b vld=%b required 1 0", o_ready, o_valid);
    end
  endtask

  // Reset during the 3rd DIVIDE cycle kills the operation for good.
  task automatic test_abort;
    bit seen;
    @(negedge i_clk);
    i_dividendo = 9'b0_0111_0000; i_divisor = 9'b0_0111_0000; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (2) @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_cociente !== 9'd0 ||
        o_overflow !== 1'b0 || o_underflow !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset: rdy=%b vld=%b q=%b ovf=%b unf=%b required 1 0 0 0 0",
               o_ready, o_valid, o_cociente, o_overflow, o_underflow);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge i_clk); #1;
      if (o_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen || o_ready !== 1'b1) begin
      errors++; $display("FAIL abort_no_result: valid_seen=%b rdy=%b required 0 1", seen, o_ready);
    end
    // block still works afterwards
    run_div("after_abort", 9'b0_0111_0000, 9'b0_0111_1000, 9'b0_0110_0101, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_limits();
    test_hold();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
